// File: rtl/g_reg_file_sb.sv
// rtl/g_reg_file_sb.sv - register file with per-register reservation scoreboard
// Optional macro G_REG_WB_BYPASS_EN: same-cycle write-back forwarding to the read ports and hazard check.
module g_reg_file_sb #(
    parameter int W_OPR    = 32,
    parameter int REG_N    = 16,
    parameter int W_RD     = $clog2(REG_N),
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W_RD-1:0]  r0_i,
    input  logic [W_RD-1:0]  r1_i,
    output logic [W_OPR-1:0] r_opr0_o,
    output logic [W_OPR-1:0] r_opr1_o,
    output logic             reserved_o,
    input  logic             w_reserve_i,
    input  logic [W_RD-1:0]  w_reserve_r_i,
    output logic             res_full_o,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic [W_OPR-1:0] result_i,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [W_OPR-1:0] data_q [REG_N];
    logic [CNT_W-1:0] cnt_q  [REG_N];
    logic             err_q;
    logic [REG_N-1:0] res_hit;
    logic [REG_N-1:0] wb_hit;
    logic             err_set;

    function automatic logic is_zero(input logic [W_RD-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    function automatic logic [W_OPR-1:0] rd_data(input logic [W_RD-1:0] idx);
        if (is_zero(idx))
            return '0;
`ifdef G_REG_WB_BYPASS_EN
        if (wb_i && (wb_r_i == idx))
            return result_i;
`endif
        return data_q[idx];
    endfunction

    // With forwarding, a write-back landing this cycle retires one pending write early.
    function automatic logic busy(input logic [W_RD-1:0] idx);
`ifdef G_REG_WB_BYPASS_EN
        if (wb_i && (wb_r_i == idx))
            return cnt_q[idx] > CNT_W'(1);
`endif
        return cnt_q[idx] != '0;
    endfunction

    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < REG_N; i++) begin
            res_hit[i] = w_reserve_i && (w_reserve_r_i == W_RD'(i)) && !is_zero(W_RD'(i));
            wb_hit[i]  = wb_i && (wb_r_i == W_RD'(i)) && !is_zero(W_RD'(i));
            if (res_hit[i] && !wb_hit[i] && (cnt_q[i] == CNT_MAX))
                err_set = 1'b1;
            if (wb_hit[i] && !res_hit[i] && (cnt_q[i] == '0))
                err_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                if (wb_hit[i])
                    data_q[i] <= result_i;
                // Counter saturates at both ends; the overflow/underflow is flagged in err_q.
                if (res_hit[i] && !wb_hit[i] && (cnt_q[i] != CNT_MAX))
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (wb_hit[i] && !res_hit[i] && (cnt_q[i] != '0))
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
            if (err_set)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        r_opr0_o   = rd_data(r0_i);
        r_opr1_o   = rd_data(r1_i);
        reserved_o = busy(r0_i) || busy(r1_i);
        res_full_o = (cnt_q[w_reserve_r_i] == CNT_MAX);
        err_o      = err_q;
    end

endmodule

// File: tb/tb_g_reg_file_sb.sv
// tb/tb_g_reg_file_sb.sv - randomized and directed bench for g_reg_file_sb against a behavioural model
module tb_g_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  r0 = '0, r1 = '0, w_reserve_r = '0, wb_r = '0;
    logic        w_reserve = 1'b0, wb = 1'b0;
    logic [31:0] result = '0;

    logic [31:0] opr0 [2];
    logic [31:0] opr1 [2];
    logic        reserved [2];
    logic        res_full [2];
    logic        err [2];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_data [2][16];
    int          m_cnt  [2][16];
    bit          m_err  [2];

    always #5 clk = ~clk;

    g_reg_file_sb #(.ZERO_REG(0)) dut (
        .clk(clk), .reset(reset), .r0_i(r0), .r1_i(r1),
        .r_opr0_o(opr0[0]), .r_opr1_o(opr1[0]), .reserved_o(reserved[0]),
        .w_reserve_i(w_reserve), .w_reserve_r_i(w_reserve_r), .res_full_o(res_full[0]),
        .wb_i(wb), .wb_r_i(wb_r), .result_i(result), .err_o(err[0])
    );

    g_reg_file_sb #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .r0_i(r0), .r1_i(r1),
        .r_opr0_o(opr0[1]), .r_opr1_o(opr1[1]), .reserved_o(reserved[1]),
        .w_reserve_i(w_reserve), .w_reserve_r_i(w_reserve_r), .res_full_o(res_full[1]),
        .wb_i(wb), .wb_r_i(wb_r), .result_i(result), .err_o(err[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: net per-register delta; a result outside 0..3 leaves the count alone and raises err.
    always @(posedge clk) begin
        for (int z = 0; z < 2; z++) begin
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    m_data[z][i] = '0;
                    m_cnt[z][i]  = 0;
                end
                m_err[z] = 1'b0;
            end else begin
                for (int i = 0; i < 16; i++) begin
                    if (!(z == 1 && i == 0)) begin
                        int d;
                        d = 0;
                        if (w_reserve && w_reserve_r == i) d = d + 1;
                        if (wb && wb_r == i) begin
                            d = d - 1;
                            m_data[z][i] = result;
                        end
                        if (m_cnt[z][i] + d > 3 || m_cnt[z][i] + d < 0)
                            m_err[z] = 1'b1;
                        else
                            m_cnt[z][i] = m_cnt[z][i] + d;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int z, input logic [3:0] idx);
        if (z == 1 && idx == 0) return '0;
`ifdef G_REG_WB_BYPASS_EN
        if (wb && wb_r == idx) return result;
`endif
        return m_data[z][idx];
    endfunction

    function automatic int eff_cnt(input int z, input logic [3:0] idx);
        int c;
        c = m_cnt[z][idx];
`ifdef G_REG_WB_BYPASS_EN
        if (wb && wb_r == idx && c > 0) c = c - 1;
`endif
        return c;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int z = 0; z < 2; z++) begin
                chk($sformatf("opr0[%0d]", z), opr0[z], exp_rd(z, r0));
                chk($sformatf("opr1[%0d]", z), opr1[z], exp_rd(z, r1));
                chk($sformatf("reserved[%0d]", z), reserved[z],
                    (eff_cnt(z, r0) > 0) || (eff_cnt(z, r1) > 0));
                chk($sformatf("res_full[%0d]", z), res_full[z], m_cnt[z][w_reserve_r] == 3);
                chk($sformatf("err[%0d]", z), err[z], m_err[z]);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        w_reserve = 1'b0;
        wb = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("reset_reserved", reserved[0], 1'b0);
        chk("reset_err", err[0], 1'b0);
        chk("reset_full", res_full[0], 1'b0);
        for (int i = 0; i < 16; i++) begin
            r0 = 4'(i);
            r1 = 4'(15 - i);
            w_reserve_r = 4'(i);
            step();
        end

        // reserve then write back r5, read it the following cycle
        w_reserve = 1'b1; w_reserve_r = 4'd5; step();
        idle(); wb = 1'b1; wb_r = 4'd5; result = 32'hDEADBEEF; step();
        idle(); r0 = 4'd5; #2;
        chk("wb_r5_data", opr0[0], 32'hDEADBEEF);
        chk("wb_r5_noerr", err[0], 1'b0);
        step();

        // fill r3 to saturation, overflow once, then drain
        r1 = 4'd3; w_reserve = 1'b1; w_reserve_r = 4'd3; step(3);
        idle(); #2;
        chk("r3_full", res_full[0], 1'b1);
        chk("r3_reserved", reserved[0], 1'b1);
        w_reserve = 1'b1; step();
        idle(); #2;
        chk("r3_overflow_err", err[0], 1'b1);
        chk("r3_still_full", res_full[0], 1'b1);
        wb = 1'b1; wb_r = 4'd3; result = 32'h0000_0333; step(2);
        idle(); #2;
        chk("r3_one_left", reserved[0], 1'b1);
        wb = 1'b1; step();
        idle(); #2;
        chk("r3_drained", reserved[0], 1'b0);
        reset = 1'b1; step(); idle();

        // r7: simultaneous reserve and write-back at count 1
        r0 = 4'd7; r1 = 4'd0;
        w_reserve = 1'b1; w_reserve_r = 4'd7; step();
        wb = 1'b1; wb_r = 4'd7; result = 32'h0000_A5A5; step();
        idle(); #2;
        chk("r7_reserved", reserved[0], 1'b1);
        chk("r7_data", opr0[0], 32'h0000_A5A5);
        chk("r7_noerr", err[0], 1'b0);
        wb = 1'b1; step(); idle(); step();

        // r9 write-back underflow, sticky error
        wb = 1'b1; wb_r = 4'd9; result = 32'h0909_0909; step();
        idle(); r0 = 4'd9; #2;
        chk("r9_data", opr0[0], 32'h0909_0909);
        chk("r9_err", err[0], 1'b1);
        step(3);
        chk("r9_err_sticky", err[0], 1'b1);
        reset = 1'b1; step(); idle(); #2;
        chk("r9_err_cleared", err[0], 1'b0);

        // register 0 on the ZERO_REG instance
        r0 = 4'd0; r1 = 4'd0;
        wb = 1'b1; wb_r = 4'd0; result = 32'h0000_1234; step();
        idle(); w_reserve = 1'b1; w_reserve_r = 4'd0; step();
        idle(); #2;
        chk("z_r0_data", opr0[1], 32'h0);
        chk("z_r0_reserved", reserved[1], 1'b0);
        chk("z_r0_err", err[1], 1'b0);
        chk("nz_r0_data", opr0[0], 32'h0000_1234);

        // reset overriding pending reserves
        r0 = 4'd2; r1 = 4'd4;
        w_reserve = 1'b1; w_reserve_r = 4'd2; step();
        w_reserve_r = 4'd4; reset = 1'b1; step();
        idle(); #2;
        chk("reset_clears_reserved", reserved[0], 1'b0);
        chk("reset_clears_reserved_z", reserved[1], 1'b0);

        // randomized traffic concentrated on a few registers to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            reset       = ($urandom_range(0, 60) == 0);
            w_reserve   = $urandom_range(0, 1);
            wb          = $urandom_range(0, 2) == 0;
            w_reserve_r = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'($urandom_range(0, 3));
            wb_r        = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'($urandom_range(0, 3));
            r0          = $urandom_range(0, 1) ? 4'($urandom) : 4'($urandom_range(0, 3));
            r1          = $urandom_range(0, 1) ? 4'($urandom) : 4'($urandom_range(0, 3));
            result      = $urandom;
            step();
        end

        idle();
        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/g_reg_file_sb.md
# g_reg_file_sb

Parametrised general-purpose register file with a per-register reservation scoreboard, successor to the fixed 16-entry register file in the register stage. Provides two combinational read ports, one write-back port and one reservation port with a separate destination index. A saturating counter per register tracks multiple outstanding writes, so back-to-back instructions may target the same destination. Decode uses `reserved_o` to stall on read-after-write hazards.

## Interface
- `W_OPR`, 32, data width of each register.
- `REG_N`, 16, number of registers, power of two, 2..64.
- `W_RD`, `$clog2(REG_N)`, register index width.
- `CNT_W`, 2, reservation counter width; max outstanding writes per register = 2^CNT_W − 1.
- `ZERO_REG`, 0, when 1 register 0 reads as zero, ignores writes and is never reserved.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `r0_i` in W_RD: read port 0 index.
- `r1_i` in W_RD: read port 1 index.
- `r_opr0_o` out W_OPR: data of register `r0_i`.
- `r_opr1_o` out W_OPR: data of register `r1_i`.
- `reserved_o` out 1: the register at `r0_i` or `r1_i` has a nonzero effective reservation count.
- `w_reserve_i` in 1: reserve register `w_reserve_r_i` (one pending write).
- `w_reserve_r_i` in W_RD: destination index to reserve.
- `res_full_o` out 1: counter of `w_reserve_r_i` is at max; a reserve now would be lost.
- `wb_i` in 1: write-back valid.
- `wb_r_i` in W_RD: write-back index.
- `result_i` in W_OPR: write-back data.
- `err_o` out 1: sticky; set on reserve overflow or write-back underflow.

## Operation
- Storage: REG_N × W_OPR data registers, REG_N × CNT_W counters, one `err` flag.
- Reset: all data 0, all counters 0, `err_o` 0. Outputs after reset: `r_opr*_o` = 0, `reserved_o` = 0, `res_full_o` = 0.
- Write-back: when `wb_i`, `result_i` is stored to `wb_r_i` at the edge. Data is written even if the counter is 0.
- Counter update per register i, at the edge: +1 if reserved (`w_reserve_i` and `w_reserve_r_i`==i), −1 if written back (`wb_i` and `wb_r_i`==i); both in the same cycle: unchanged.
- Overflow: reserve alone on a counter at max: counter holds at max and `err` is set. Reserve together with write-back on the same register at max: net unchanged, no error.
- Underflow: write-back alone on a counter at 0: counter holds at 0, data is written, `err` is set.
- `err` clears only on `reset`.
- `ZERO_REG`=1: index 0 reads 0, writes to it are dropped, its counter stays 0, and reserve/write-back on it never set `err`.
- `reserved_o` = (cnt[r0_i] ≠ 0) | (cnt[r1_i] ≠ 0), subject to bypass (see Configuration).
- `res_full_o` = (cnt[w_reserve_r_i] == max), combinational, independent of `w_reserve_i`.

## Timing
- Reads are combinational from the current state: 0-cycle latency.
- Write-back data is visible on a read port the cycle after `wb_i` (without bypass).
- Reservation is visible in `reserved_o` the cycle after `w_reserve_i`.
- Reserve followed by write-back on the next cycle: counter 0→1→0; `reserved_o` is high for exactly one cycle.
- `reset` mid-operation overrides any simultaneous reserve or write-back in that cycle.

## Configuration
- `G_REG_WB_BYPASS_EN` defined: a read index equal to `wb_r_i` while `wb_i` is high returns `result_i` in the same cycle (except register 0 when ZERO_REG=1). The reservation test for that index uses cnt − 1 (floored at 0), so a final pending write landing this cycle does not stall.
- Not defined: reads and `reserved_o` reflect registered state only; a same-cycle write-back is not seen until the next cycle.

## Test plan
- Reset, then read all indices -> every `r_opr*_o` = 0; `reserved_o`, `res_full_o`, `err_o` = 0.
- Write 0xDEADBEEF to r5, next cycle r0_i=5 -> `r_opr0_o` = 0xDEADBEEF. With bypass: same-cycle read returns 0xDEADBEEF.
- Reserve r3 three times (CNT_W=2) -> `res_full_o`=1 while `w_reserve_r_i`=3. Fourth reserve -> `err_o`=1 and the counter stays 3. Three write-backs -> `reserved_o` for r1_i=3 falls after the third (same cycle as the third write-back with bypass).
- Simultaneous reserve and write-back to r7 with count 1 -> count stays 1, `reserved_o` stays 1, data updated.
- Write-back to r9 with count 0 -> data written, `err_o`=1 and sticky until `reset`.
- ZERO_REG=1: write 0x1234 to r0, reserve r0 -> `r_opr0_o`=0, `reserved_o`=0, `err_o`=0. Assert `reset` during pending reserves -> all counters 0 next cycle.
